barrel_shifter_pipe: RTL and testbench

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

---
 rtl/shifter_pkg.sv | 20 ++
 rtl/shifter_level.sv | 37 +++
 rtl/barrel_shifter_pipe.sv | 104 ++++++++++
 tb/tb_barrel_shifter_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg: op encodings, default width and op legality; SHIFTER_ROTATE_EN makes ROR/ROL legal
package shifter_pkg;
    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROR = 3'b011,
        OP_ROL = 3'b100
    } shift_op_e;

    function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFTER_ROTATE_EN
        return op <= OP_ROL;
`else
        return op <= OP_SRA;
`endif
    endfunction
endpackage

// File: rtl/shifter_level.sv
// shifter_level: one 2^K mux level; SHIFTER_ROTATE_EN adds the rotate wrap paths
module shifter_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic [2:0]       op_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] d_o
);
    localparam int S = 1 << K;
    localparam logic [WIDTH-1:0] HI = ~({WIDTH{1'b1}} >> S);

    logic [WIDTH-1:0] sll, srl, sh;

    assign sll = d_i << S;
    assign srl = d_i >> S;

    // pick the shifted word for this op; unsupported ops collapse to zero at every level
    always_comb begin
`ifdef SHIFTER_ROTATE_EN
        sh = op_i == OP_SLL ? sll :
             op_i == OP_SRL ? srl :
             op_i == OP_SRA ? srl | (HI & {WIDTH{fill_i}}) :
             op_i == OP_ROR ? srl | (d_i << (WIDTH - S)) :
             op_i == OP_ROL ? sll | (d_i >> (WIDTH - S)) : '0;
`else
        sh = op_i == OP_SLL ? sll :
             op_i == OP_SRL ? srl :
             op_i == OP_SRA ? srl | (HI & {WIDTH{fill_i}}) : '0;
`endif
        d_o = !op_legal(op_i) ? '0 : en_i ? sh : d_i;
    end
endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: elastic log2-staged barrel shifter; SHIFTER_ROTATE_EN enables ROR/ROL
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int REG_EVERY = 1,
    localparam int SHAMT_W  = $clog2(WIDTH),
    localparam int LAT      = (SHAMT_W + REG_EVERY - 1) / REG_EVERY
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [2:0]         op_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   result_o,
    output logic               illegal_o
);
    logic [LAT:1]       valid_q, rdy;
    logic [LAT:0]       up_v;
    logic [WIDTH-1:0]   data_q [1:LAT];
    logic [WIDTH-1:0]   data_d [1:LAT];
    logic [2:0]         op_q   [1:LAT];
    logic [2:0]         op_up  [1:LAT];
    logic [SHAMT_W-1:0] sh_q   [1:LAT];
    logic [SHAMT_W-1:0] sh_up  [1:LAT];
    logic [WIDTH-1:0]   lv     [0:SHAMT_W-1];
    logic               acc;

    assign up_v        = {valid_q, in_valid_i};
    assign in_ready_o  = rdy[1];
    assign out_valid_o = valid_q[LAT];
    assign result_o    = data_q[LAT];
    assign illegal_o   = !op_legal(op_q[LAT]);

    // op/shamt feeding stage s come from the ports or the previous slot
    for (genvar s = 1; s <= LAT; s++) begin : g_up
        if (s == 1) begin : g_in
            assign op_up[s] = op_i;
            assign sh_up[s] = shamt_i;
        end else begin : g_mid
            assign op_up[s] = op_q[s-1];
            assign sh_up[s] = sh_q[s-1];
        end
    end

    // levels in register group t read their controls from op_up/sh_up[t+1]
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
        localparam int T = k / REG_EVERY;
        logic [WIDTH-1:0] din;
        if (k == 0) begin : g_first
            assign din = data_i;
        end else if (k % REG_EVERY == 0) begin : g_reg
            assign din = data_q[T];
        end else begin : g_chain
            assign din = lv[k-1];
        end
        shifter_level #(.WIDTH(WIDTH), .K(k)) u_lvl (
            .d_i   (din),
            .en_i  (sh_up[T+1][k]),
            .op_i  (op_up[T+1]),
            .fill_i(din[WIDTH-1]),
            .d_o   (lv[k])
        );
        if ((k + 1) % REG_EVERY == 0 || k == SHAMT_W - 1) begin : g_cap
            assign data_d[T+1] = lv[k];
        end
    end

    // a slot may load when it is empty or every slot downstream can advance
    always_comb begin
        acc = out_ready_i;
        rdy = '0;
        for (int s = LAT; s >= 1; s--) begin
            acc = acc || !valid_q[s];
            rdy[s] = acc;
        end
    end

    // advance elastic slots; flush drops valids only, reset also zeroes payload
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int s = 1; s <= LAT; s++) begin
                data_q[s] <= '0;
                op_q[s]   <= OP_SLL;
                sh_q[s]   <= '0;
            end
        end else begin
            for (int s = 1; s <= LAT; s++) begin
                valid_q[s] <= flush_i ? 1'b0 : rdy[s] ? up_v[s-1] : valid_q[s];
                if (rdy[s] && up_v[s-1]) begin
                    data_q[s] <= data_d[s];
                    op_q[s]   <= op_up[s];
                    sh_q[s]   <= sh_up[s];
                end
            end
        end
    end
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: scoreboard bench over REG_EVERY = 1, 2, 5 lanes
module tb_barrel_shifter_pipe;
    localparam int N = 3;
    localparam int RES [N] = '{1, 2, 5};
`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] r;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [N];
    logic        flush     [N];
    logic        in_valid  [N];
    logic        in_ready  [N];
    logic [31:0] data      [N];
    logic [4:0]  shamt     [N];
    logic [2:0]  op        [N];
    logic        out_valid [N];
    logic        out_ready [N];
    logic [31:0] result    [N];
    logic        illegal   [N];
    bit          rnd_rdy   [N];
    exp_t        exp_q     [N][$];
    int          pass_cnt = 0;
    int          total = 0;

    logic [31:0] tc_d  [12] = '{32'hF0000000, 32'h00000001, 32'h12345678, 32'h9ABCDEF0,
                                32'h80000001, 32'hDEADBEEF, 32'hC0FFEE00, 32'h00000001,
                                32'h80000000, 32'h13579BDF, 32'h2468ACE0, 32'hFFFFFFFF};
    logic [4:0]  tc_s  [12] = '{5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd3, 5'd17, 5'd31};
    logic [2:0]  tc_op [12] = '{3'd2, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [31:0] d, input logic [4:0] s, input logic [2:0] o);
        exp_t e;
        logic [63:0] dd, t;
        dd = {d, d};
        e.ill = 1'b0;
        e.r = 32'd0;
        if (o == 3'd0) e.r = d << s;
        else if (o == 3'd1) e.r = d >> s;
        else if (o == 3'd2) e.r = $signed(d) >>> s;
        else if (ROT && o == 3'd3) begin t = dd >> s; e.r = t[31:0]; end
        else if (ROT && o == 3'd4) begin t = dd << s; e.r = t[63:32]; end
        else e.ill = 1'b1;
        return e;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_lane
        exp_t held, e;
        bit   stall = 1'b0;
        barrel_shifter_pipe #(.WIDTH(32), .REG_EVERY(RES[g])) dut (
            .clk_i      (clk),
            .rst_i      (rst[g]),
            .flush_i    (flush[g]),
            .in_valid_i (in_valid[g]),
            .in_ready_o (in_ready[g]),
            .data_i     (data[g]),
            .shamt_i    (shamt[g]),
            .op_i       (op[g]),
            .out_valid_o(out_valid[g]),
            .out_ready_i(out_ready[g]),
            .result_o   (result[g]),
            .illegal_o  (illegal[g])
        );

        always @(negedge clk) begin
            if (rst[g]) begin
                exp_q[g].delete();
                stall = 1'b0;
            end else begin
                if (stall)
                    chk($sformatf("hold%0d", g), {out_valid[g], illegal[g], result[g]}, {1'b1, held.ill, held.r});
                stall = out_valid[g] && !out_ready[g] && !flush[g];
                held.r = result[g];
                held.ill = illegal[g];
                if (out_valid[g] && out_ready[g]) begin
                    if (exp_q[g].size() == 0) chk($sformatf("spurious%0d", g), 64'(out_valid[g]), 64'd0);
                    else begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("result%0d", g), {illegal[g], result[g]}, {e.ill, e.r});
                    end
                end
                if (flush[g]) exp_q[g].delete();
            end
        end
    end

    task automatic send(input int l, input logic [31:0] d, input logic [4:0] s, input logic [2:0] o,
                        input int bound, output bit ok, output int cyc);
        in_valid[l] = 1'b1;
        data[l] = d;
        shamt[l] = s;
        op[l] = o;
        ok = 1'b0;
        cyc = 0;
        while (cyc < bound && !ok) begin
            @(negedge clk);
            if (in_ready[l] && !flush[l] && !rst[l]) begin
                ok = 1'b1;
                exp_q[l].push_back(model(d, s, o));
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rnd_rdy[l]) out_ready[l] = 1'($urandom_range(0, 1));
        end
        in_valid[l] = 1'b0;
    endtask

    task automatic tick(input int l, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_rdy[l]) out_ready[l] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic measure(input int l, input logic [31:0] d, input logic [4:0] s, input logic [2:0] o,
                           input int exp_lat, input logic [31:0] exp_r);
        bit ok;
        int cyc, n;
        logic [31:0] r;
        n = 0;
        r = 'x;
        send(l, d, s, o, 4, ok, cyc);
        chk($sformatf("lat_accept%0d", l), 64'(ok), 64'd1);
        for (int c = 1; c <= 20 && n == 0; c++) begin
            @(negedge clk);
            if (out_valid[l]) begin n = c; r = result[l]; end
        end
        chk($sformatf("latency%0d", l), 64'(n), 64'(exp_lat));
        chk($sformatf("lat_result%0d", l), 64'(r), 64'(exp_r));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total);
        $fatal(1);
    end

    initial begin
        bit ok;
        int cyc, thr, cnt;
        logic [31:0] bd [8];
        for (int l = 0; l < N; l++) begin
            rst[l] = 1'b1; flush[l] = 1'b0; in_valid[l] = 1'b0; data[l] = '0;
            shamt[l] = '0; op[l] = '0; out_ready[l] = 1'b1; rnd_rdy[l] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int l = 0; l < N; l++) rst[l] = 1'b0;
        @(negedge clk);
        for (int l = 0; l < N; l++)
            chk($sformatf("reset%0d", l), {out_valid[l], in_ready[l], illegal[l], result[l]}, {1'b0, 1'b1, 1'b0, 32'd0});
        @(posedge clk);
        #1;

        measure(0, 32'h80000000, 5'd31, 3'd1, 5, 32'h00000001);
        measure(1, 32'h80000000, 5'd31, 3'd1, 3, 32'h00000001);
        measure(2, 32'h80000000, 5'd31, 3'd1, 1, 32'h00000001);

        thr = 0;
        for (int i = 0; i < 12; i++) begin
            send(0, tc_d[i], tc_s[i], tc_op[i], 4, ok, cyc);
            thr += cyc;
        end
        chk("throughput", 64'(thr), 64'd12);
        tick(0, 8);
        chk("drain_directed", 64'(exp_q[0].size()), 64'd0);

        for (int i = 0; i < 8; i++) bd[i] = $urandom;
        out_ready[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            send(0, bd[i], 5'(i), 3'd1, 2, ok, cyc);
            cnt += int'(ok);
        end
        chk("bp_accepted", 64'(cnt), 64'd5);
        send(0, bd[5], 5'd5, 3'd1, 4, ok, cyc);
        chk("bp_full_reject", 64'(ok), 64'd0);
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        for (int i = 5; i < 8; i++) begin
            send(0, bd[i], 5'(i), 3'd1, 4, ok, cyc);
            chk("bp_resume", 64'(ok), 64'd1);
        end
        tick(0, 8);
        chk("drain_bp", 64'(exp_q[0].size()), 64'd0);

        for (int i = 0; i < 3; i++) send(0, $urandom, 5'(i + 2), 3'd0, 2, ok, cyc);
        flush[0] = 1'b1;
        in_valid[0] = 1'b1;
        data[0] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        in_valid[0] = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(out_valid[0]);
        end
        chk("flush_empty", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        measure(0, 32'h00000001, 5'd31, 3'd0, 5, 32'h80000000);

        for (int l = 0; l < N; l++) begin
            rnd_rdy[l] = 1'b1;
            for (int i = 0; i < 300; i++) begin
                if (i == 150) begin
                    rst[l] = 1'b1;
                    @(posedge clk);
                    #1;
                    rst[l] = 1'b0;
                    @(negedge clk);
                    chk($sformatf("rst_mid%0d", l), {out_valid[l], in_ready[l], illegal[l], result[l]},
                        {1'b0, 1'b1, 1'b0, 32'd0});
                    @(posedge clk);
                    #1;
                end
                send(l, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 40, ok, cyc);
                chk($sformatf("rand_accept%0d", l), 64'(ok), 64'd1);
                if ($urandom_range(0, 3) == 0) tick(l, $urandom_range(1, 3));
            end
            rnd_rdy[l] = 1'b0;
            out_ready[l] = 1'b1;
            for (int c = 0; c < 40 && exp_q[l].size() != 0; c++) @(posedge clk);
            @(posedge clk);
            #1;
            chk($sformatf("drain_rand%0d", l), 64'(exp_q[l].size()), 64'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
